// File: rtl/jtframe_ddr_romstream.sv
// jtframe_ddr_romstream
// Streams a contiguous DDRAM region into the core's ROM programming port.
// DDR bursts fill one bank of a ping-pong buffer while the other bank is
// serialised into prog_* units, so reads and core writes overlap.
module jtframe_ddr_romstream #(
    parameter int         BW   = 7,     // log2 of burst length in 64-bit words
    parameter int         DW   = 8,     // output unit width: 8 or 16
    parameter logic [3:0] BASE = 4'd3   // top nibble of ddram_addr
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [26:0]   len,
    output logic          busy,
    output logic          done,
    input  logic          ddram_busy,
    output logic [7:0]    ddram_burstcnt,
    output logic [28:0]   ddram_addr,
    output logic          ddram_rd,
    input  logic [63:0]   ddram_dout,
    input  logic          ddram_dout_ready,
    output logic [26:0]   prog_addr,
    output logic [DW-1:0] prog_data,
    output logic          prog_we,
    input  logic          prog_rdy
);

    localparam int NW   = 1 << BW;            // words per burst / per bank
    localparam int PW   = 25 - BW;            // page counter width
    localparam int UL   = (DW == 16) ? 2 : 3; // log2 of units per 64-bit word
    localparam int UW   = BW + UL;            // unit index width within a bank
    localparam int STEP = DW / 8;             // bytes per unit

    // F_DROP swallows the rest of a burst that was in flight when the
    // transfer ended, so a later transfer never sees stale words.
    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_DROP = 2'd3
    } fill_state_t;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WAIT = 2'd1,
        D_SEND = 2'd2
    } drain_state_t;

    // Little-endian unit select: unit 0 is the least significant DW bits.
    function automatic logic [DW-1:0] pick_unit(input logic [63:0] word,
                                                input logic [UL-1:0] sub);
        logic [DW-1:0] u;
        u = word[int'(sub) * DW +: DW];
        return u;
    endfunction

    fill_state_t   fill_state_q,  fill_state_d;
    drain_state_t  drain_state_q, drain_state_d;
    logic          busy_q,        busy_d;
    logic          done_q,        done_d;
    logic [26:0]   len_q,         len_d;
    logic [PW-1:0] page_q,        page_d;
    logic [BW-1:0] cnt_q,         cnt_d;
    logic          fill_bank_q,   fill_bank_d;
    logic          drain_bank_q,  drain_bank_d;
    logic [1:0]    full_q,        full_d;
    logic [28:0]   addr_q,        addr_d;
    logic [UW-1:0] unit_q,        unit_d;
    logic [26:0]   prog_addr_q,   prog_addr_d;
    logic [DW-1:0] prog_data_q,   prog_data_d;
    logic          prog_we_q,     prog_we_d;

    logic [63:0]   mem_q [0:2*NW-1];
    logic          mem_we_s;
    logic [BW:0]   mem_waddr_s;
    logic          rd_s;
    logic          accept_s;
    logic          term_s;
    logic [27:0]   fetched_s;

    // Next-state logic for both FSMs, buffer flags and the prog port
    always_comb begin
        fill_state_d  = fill_state_q;
        drain_state_d = drain_state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        len_d         = len_q;
        page_d        = page_q;
        cnt_d         = cnt_q;
        fill_bank_d   = fill_bank_q;
        drain_bank_d  = drain_bank_q;
        full_d        = full_q;
        addr_d        = addr_q;
        unit_d        = unit_q;
        prog_addr_d   = prog_addr_q;
        prog_data_d   = prog_data_q;
        prog_we_d     = prog_we_q;
        mem_we_s      = 1'b0;
        mem_waddr_s   = {fill_bank_q, cnt_q};
        // bytes fetched once the burst now in progress has completed
        fetched_s     = {page_q + PW'(1), {(BW + 3){1'b0}}};
        accept_s      = (drain_state_q == D_SEND) && prog_we_q && prog_rdy;
        term_s        = accept_s &&
                        (({1'b0, prog_addr_q} + 28'(STEP)) >= {1'b0, len_q});
        rd_s          = (fill_state_q == F_REQ) && !ddram_busy &&
                        !full_q[fill_bank_q] && !term_s;

        case (fill_state_q)
            F_IDLE: begin
                if (start && !busy_q) begin
                    if (len == 27'd0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d        = 1'b1;
                        len_d         = len;
                        page_d        = {PW{1'b0}};
                        cnt_d         = {BW{1'b0}};
                        fill_bank_d   = 1'b0;
                        drain_bank_d  = 1'b0;
                        full_d        = 2'b00;
                        unit_d        = {UW{1'b0}};
                        prog_addr_d   = 27'd0;
                        addr_d        = {BASE, {PW{1'b0}}, {BW{1'b0}}};
                        fill_state_d  = F_REQ;
                        drain_state_d = D_WAIT;
                    end
                end else begin
                    fill_state_d = F_IDLE;
                end
            end
            F_REQ: begin
                if (rd_s) begin
                    fill_state_d = F_WAIT;
                end else begin
                    fill_state_d = F_REQ;
                end
            end
            F_WAIT: begin
                if (ddram_dout_ready) begin
                    mem_we_s = 1'b1;
                    cnt_d    = cnt_q + BW'(1);
                    if (cnt_q == {BW{1'b1}}) begin
                        full_d[fill_bank_q] = 1'b1;
                        fill_bank_d         = ~fill_bank_q;
                        page_d              = page_q + PW'(1);
                        addr_d              = {BASE, page_q + PW'(1), {BW{1'b0}}};
                        if (fetched_s < {1'b0, len_q}) begin
                            fill_state_d = F_REQ;
                        end else begin
                            fill_state_d = F_IDLE;
                        end
                    end else begin
                        fill_state_d = F_WAIT;
                    end
                end else begin
                    fill_state_d = F_WAIT;
                end
            end
            F_DROP: begin
                if (ddram_dout_ready) begin
                    cnt_d = cnt_q + BW'(1);
                    if (cnt_q == {BW{1'b1}}) begin
                        fill_state_d = F_IDLE;
                    end else begin
                        fill_state_d = F_DROP;
                    end
                end else begin
                    fill_state_d = F_DROP;
                end
            end
            default: fill_state_d = F_IDLE;
        endcase

        case (drain_state_q)
            D_IDLE: begin
                // a new start moves the drain side on from the fill branch
                prog_we_d = 1'b0;
            end
            D_WAIT: begin
                if (full_q[drain_bank_q]) begin
                    drain_state_d = D_SEND;
                    prog_we_d     = 1'b1;
                    prog_data_d   = pick_unit(mem_q[{drain_bank_q, unit_q[UW-1:UL]}],
                                              unit_q[UL-1:0]);
                end else begin
                    drain_state_d = D_WAIT;
                end
            end
            D_SEND: begin
                if (term_s) begin
                    // last byte accepted: end the transfer, drop leftovers
                    prog_we_d     = 1'b0;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                    full_d        = 2'b00;
                    drain_state_d = D_IDLE;
                    fill_state_d  = (fill_state_d == F_WAIT) ? F_DROP : F_IDLE;
                end else if (accept_s) begin
                    prog_addr_d = prog_addr_q + 27'(STEP);
                    if (unit_q == {UW{1'b1}}) begin
                        full_d[drain_bank_q] = 1'b0;
                        drain_bank_d         = ~drain_bank_q;
                        unit_d               = {UW{1'b0}};
                        // keep streaming if the other bank is already waiting
                        if (full_q[~drain_bank_q]) begin
                            prog_we_d   = 1'b1;
                            prog_data_d = pick_unit(mem_q[{~drain_bank_q, {BW{1'b0}}}],
                                                    {UL{1'b0}});
                        end else begin
                            prog_we_d     = 1'b0;
                            drain_state_d = D_WAIT;
                        end
                    end else begin
                        unit_d      = unit_q + UW'(1);
                        prog_data_d = pick_unit(mem_q[{drain_bank_q, unit_d[UW-1:UL]}],
                                                unit_d[UL-1:0]);
                    end
                end else begin
                    prog_we_d = prog_we_q;
                end
            end
            default: drain_state_d = D_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_state_q  <= F_IDLE;
            drain_state_q <= D_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            len_q         <= 27'd0;
            page_q        <= {PW{1'b0}};
            cnt_q         <= {BW{1'b0}};
            fill_bank_q   <= 1'b0;
            drain_bank_q  <= 1'b0;
            full_q        <= 2'b00;
            addr_q        <= 29'd0;
            unit_q        <= {UW{1'b0}};
            prog_addr_q   <= 27'd0;
            prog_data_q   <= {DW{1'b0}};
            prog_we_q     <= 1'b0;
        end else begin
            fill_state_q  <= fill_state_d;
            drain_state_q <= drain_state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            len_q         <= len_d;
            page_q        <= page_d;
            cnt_q         <= cnt_d;
            fill_bank_q   <= fill_bank_d;
            drain_bank_q  <= drain_bank_d;
            full_q        <= full_d;
            addr_q        <= addr_d;
            unit_q        <= unit_d;
            prog_addr_q   <= prog_addr_d;
            prog_data_q   <= prog_data_d;
            prog_we_q     <= prog_we_d;
        end
    end

    // Burst words land in the fill bank as they arrive
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= ddram_dout;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign ddram_burstcnt = 8'(NW);
    assign ddram_addr     = addr_q;
    assign ddram_rd       = rd_s;
    assign prog_addr      = prog_addr_q;
    assign prog_data      = prog_data_q;
    assign prog_we        = prog_we_q;

endmodule

// File: tb/tb_jtframe_ddr_romstream.sv
// Directed bench for jtframe_ddr_romstream: a DW=8 and a DW=16 instance,
// each fed by a small DDR burst model; accepted prog units are logged and
// compared against a byte pattern computed from the byte offset.
module tb_jtframe_ddr_romstream;

    localparam int BW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic busy_mode = 1'b0;
    logic rdy_mode = 1'b0;

    logic a_start = 1'b0; logic [26:0] a_len = 27'd0;
    logic a_busy, a_done, a_rd, a_we;
    logic a_ddr_busy = 1'b0; logic a_drdy = 1'b0; logic a_prdy = 1'b1;
    logic [7:0] a_bcnt; logic [28:0] a_addr; logic [63:0] a_dout = 64'd0;
    logic [26:0] a_paddr; logic [7:0] a_pdata;

    logic b_start = 1'b0; logic [26:0] b_len = 27'd0;
    logic b_busy, b_done, b_rd, b_we;
    logic b_drdy = 1'b0;
    logic [7:0] b_bcnt; logic [28:0] b_addr; logic [63:0] b_dout = 64'd0;
    logic [26:0] b_paddr; logic [15:0] b_pdata;

    always #5 clk = ~clk;

    jtframe_ddr_romstream #(.BW(BW), .DW(8), .BASE(4'd3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .len(a_len),
        .busy(a_busy), .done(a_done), .ddram_busy(a_ddr_busy),
        .ddram_burstcnt(a_bcnt), .ddram_addr(a_addr), .ddram_rd(a_rd),
        .ddram_dout(a_dout), .ddram_dout_ready(a_drdy),
        .prog_addr(a_paddr), .prog_data(a_pdata), .prog_we(a_we), .prog_rdy(a_prdy)
    );

    jtframe_ddr_romstream #(.BW(BW), .DW(16), .BASE(4'd3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .len(b_len),
        .busy(b_busy), .done(b_done), .ddram_busy(1'b0),
        .ddram_burstcnt(b_bcnt), .ddram_addr(b_addr), .ddram_rd(b_rd),
        .ddram_dout(b_dout), .ddram_dout_ready(b_drdy),
        .prog_addr(b_paddr), .prog_data(b_pdata), .prog_we(b_we), .prog_rdy(1'b1)
    );

    // byte value stored at a given byte offset of the region
    function automatic logic [7:0] pat(input int b);
        logic [7:0] lo, hi;
        lo = b[7:0];
        hi = b[15:8];
        return lo ^ hi ^ 8'h5A;
    endfunction

    function automatic logic [63:0] word_of(input logic [28:0] base, input int k);
        logic [63:0] w;
        int rel;
        rel = int'(base - 29'h600_0000) + k;
        for (int j = 0; j < 8; j++) w[j*8 +: 8] = pat(rel * 8 + j);
        return w;
    endfunction

    logic [28:0] a_rd_q[$]; int a_rd_cyc_q[$]; int a_bend_q[$];
    logic [26:0] a_wa_q[$]; logic [7:0] a_wd_q[$]; int a_wc_q[$];
    int a_done_q[$]; int a_start_q[$]; int a_viol = 0;
    logic [26:0] b_wa_q[$]; logic [15:0] b_wd_q[$];
    int b_rd_n = 0; int b_done_n = 0;
    int a_pend = 0, a_wait = 0, a_widx = 0; logic [28:0] a_base = 29'd0;
    int b_pend = 0, b_wait = 0, b_widx = 0; logic [28:0] b_base = 29'd0;

    // DDR models and output logging, one step per cycle at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            a_ddr_busy = busy_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            a_prdy = rdy_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
            a_drdy = 1'b0;
            b_drdy = 1'b0;
            if (!rst_n) begin a_pend = 0; b_pend = 0; end
            if (a_pend > 0) begin
                if (a_wait > 0) a_wait--;
                else if (!busy_mode || $urandom_range(0, 1) == 0) begin
                    a_dout = word_of(a_base, a_widx);
                    a_drdy = 1'b1;
                    if (a_widx == 7) a_bend_q.push_back(cyc);
                    a_widx++; a_pend--;
                end
            end
            if (b_pend > 0) begin
                if (b_wait > 0) b_wait--;
                else begin
                    b_dout = word_of(b_base, b_widx);
                    b_drdy = 1'b1;
                    b_widx++; b_pend--;
                end
            end
            #1;
            if (a_start && !a_busy) a_start_q.push_back(cyc);
            if (a_rd) begin
                if (a_ddr_busy) a_viol++;
                a_rd_q.push_back(a_addr); a_rd_cyc_q.push_back(cyc);
                a_base = a_addr; a_widx = 0; a_pend = 8; a_wait = 2;
            end
            if (a_we && a_prdy) begin
                a_wa_q.push_back(a_paddr); a_wd_q.push_back(a_pdata); a_wc_q.push_back(cyc);
            end
            if (a_done) a_done_q.push_back(cyc);
            if (b_rd) begin
                b_rd_n++; b_base = b_addr; b_widx = 0; b_pend = 8; b_wait = 2;
            end
            if (b_we) begin b_wa_q.push_back(b_paddr); b_wd_q.push_back(b_pdata); end
            if (b_done) b_done_n++;
        end
    end

    task automatic pulse_a(input logic [26:0] l);
        @(negedge clk);
        a_len = l; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a_done(input int target);
        int n = 0;
        while (a_done_q.size() < target && n < 5000) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({a_busy, a_done, a_rd, a_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl_a: got %b want 0000", {a_busy, a_done, a_rd, a_we});
        end
        checks++;
        if ({a_addr, a_paddr, a_pdata} !== 64'd0) begin
            errors++; $display("FAIL reset_regs_a: got addr %h paddr %h data %h want 0", a_addr, a_paddr, a_pdata);
        end
        checks++;
        if (a_bcnt !== 8'd8) begin errors++; $display("FAIL reset_burstcnt: got %0d want 8", a_bcnt); end
        checks++;
        if ({b_busy, b_done, b_rd, b_we, b_addr, b_paddr, b_pdata} !== 75'd0) begin
            errors++; $display("FAIL reset_b: got nonzero outputs");
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_len64();
        int r0 = a_rd_q.size(); int w0 = a_wa_q.size(); int d0 = a_done_q.size();
        int s0 = a_start_q.size(); int b0 = a_bend_q.size();
        pulse_a(27'd64);
        wait_a_done(d0 + 1);
        checks++;
        if (a_rd_q.size() - r0 != 1) begin errors++; $display("FAIL len64_rd_count: got %0d want 1", a_rd_q.size() - r0); end
        checks++;
        if (a_rd_q.size() > r0 && a_rd_q[r0] !== 29'h600_0000) begin
            errors++; $display("FAIL len64_rd_addr: got %h want 6000000", a_rd_q[r0]);
        end
        checks++;
        if (a_rd_q.size() > r0 && a_start_q.size() > s0 && a_rd_cyc_q[r0] != a_start_q[s0] + 1) begin
            errors++; $display("FAIL len64_rd_latency: got cycle %0d want %0d", a_rd_cyc_q[r0], a_start_q[s0] + 1);
        end
        checks++;
        if (a_wa_q.size() - w0 != 64) begin errors++; $display("FAIL len64_we_count: got %0d want 64", a_wa_q.size() - w0); end
        for (int i = 0; i < 64 && w0 + i < a_wa_q.size(); i++) begin
            checks++;
            if (a_wa_q[w0+i] !== 27'(i) || a_wd_q[w0+i] !== pat(i)) begin
                errors++; $display("FAIL len64_unit%0d: got addr %0d data %h want addr %0d data %h", i, a_wa_q[w0+i], a_wd_q[w0+i], i, pat(i));
            end
        end
        checks++;
        if (a_bend_q.size() > b0 && a_wc_q.size() > w0 && a_wc_q[w0] <= a_bend_q[b0]) begin
            errors++; $display("FAIL len64_first_we: got cycle %0d want > %0d", a_wc_q[w0], a_bend_q[b0]);
        end
        checks++;
        if (a_done_q.size() - d0 != 1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL len64_done: got %0d pulses busy %b want 1 pulse busy 0", a_done_q.size() - d0, a_busy);
        end
    endtask

    task automatic test_len200();
        int r0 = a_rd_q.size(); int w0 = a_wa_q.size(); int d0 = a_done_q.size();
        pulse_a(27'd200);
        wait_a_done(d0 + 1);
        checks++;
        if (a_rd_q.size() - r0 != 4) begin errors++; $display("FAIL len200_rd_count: got %0d want 4", a_rd_q.size() - r0); end
        for (int p = 0; p < 4 && r0 + p < a_rd_q.size(); p++) begin
            checks++;
            if (a_rd_q[r0+p] !== 29'h600_0000 + 29'(8 * p)) begin
                errors++; $display("FAIL len200_page%0d: got %h want %h", p, a_rd_q[r0+p], 29'h600_0000 + 29'(8 * p));
            end
        end
        checks++;
        if (a_wa_q.size() - w0 != 200) begin errors++; $display("FAIL len200_we_count: got %0d want 200", a_wa_q.size() - w0); end
        checks++;
        if (a_wa_q.size() > 0 && a_wa_q[a_wa_q.size()-1] !== 27'd199) begin
            errors++; $display("FAIL len200_last_addr: got %0d want 199", a_wa_q[a_wa_q.size()-1]);
        end
        for (int i = 0; i < 200 && w0 + i < a_wa_q.size(); i++) begin
            checks++;
            if (a_wa_q[w0+i] !== 27'(i) || a_wd_q[w0+i] !== pat(i)) begin
                errors++; $display("FAIL len200_unit%0d: got addr %0d data %h want data %h", i, a_wa_q[w0+i], a_wd_q[w0+i], pat(i));
            end
        end
        checks++;
        if (a_done_q.size() - d0 != 1) begin errors++; $display("FAIL len200_done: got %0d want 1", a_done_q.size() - d0); end
    endtask

    task automatic test_random();
        int r0 = a_rd_q.size(); int w0 = a_wa_q.size(); int d0 = a_done_q.size(); int v0 = a_viol;
        busy_mode = 1'b1; rdy_mode = 1'b1;
        pulse_a(27'd300);
        wait_a_done(d0 + 1);
        busy_mode = 1'b0; rdy_mode = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (a_wa_q.size() - w0 != 300) begin errors++; $display("FAIL random_we_count: got %0d want 300", a_wa_q.size() - w0); end
        for (int i = 0; i < 300 && w0 + i < a_wa_q.size(); i++) begin
            checks++;
            if (a_wa_q[w0+i] !== 27'(i) || a_wd_q[w0+i] !== pat(i)) begin
                errors++; $display("FAIL random_unit%0d: got addr %0d data %h want data %h", i, a_wa_q[w0+i], a_wd_q[w0+i], pat(i));
            end
        end
        checks++;
        if (a_viol != v0) begin errors++; $display("FAIL random_rd_while_busy: got %0d want 0", a_viol - v0); end
        checks++;
        if (a_rd_q.size() - r0 != 5) begin errors++; $display("FAIL random_rd_count: got %0d want 5", a_rd_q.size() - r0); end
        checks++;
        if (a_done_q.size() - d0 != 1) begin errors++; $display("FAIL random_done: got %0d want 1", a_done_q.size() - d0); end
    endtask

    task automatic test_dw16();
        int w0 = b_wa_q.size(); int r0 = b_rd_n; int d0 = b_done_n; int n = 0;
        logic [15:0] exp;
        @(negedge clk);
        b_len = 27'd17; b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        while (b_done_n == d0 && n < 2000) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
        checks++;
        if (b_wa_q.size() - w0 != 9) begin errors++; $display("FAIL dw16_we_count: got %0d want 9", b_wa_q.size() - w0); end
        for (int i = 0; i < 9 && w0 + i < b_wa_q.size(); i++) begin
            exp = {pat(2 * i + 1), pat(2 * i)};
            checks++;
            if (b_wa_q[w0+i] !== 27'(2 * i) || b_wd_q[w0+i] !== exp) begin
                errors++; $display("FAIL dw16_unit%0d: got addr %0d data %h want addr %0d data %h", i, b_wa_q[w0+i], b_wd_q[w0+i], 2 * i, exp);
            end
        end
        checks++;
        if (b_rd_n - r0 != 1 || b_done_n - d0 != 1) begin
            errors++; $display("FAIL dw16_rd_done: got rd %0d done %0d want 1 and 1", b_rd_n - r0, b_done_n - d0);
        end
    endtask

    task automatic test_len0_and_busy_start();
        int r0 = a_rd_q.size(); int w0 = a_wa_q.size(); int d0 = a_done_q.size(); int s0 = a_start_q.size();
        pulse_a(27'd0);
        repeat (6) @(negedge clk);
        checks++;
        if (a_done_q.size() - d0 != 1) begin errors++; $display("FAIL len0_done_count: got %0d want 1", a_done_q.size() - d0); end
        checks++;
        if (a_done_q.size() > d0 && a_start_q.size() > s0 && a_done_q[d0] != a_start_q[s0] + 1) begin
            errors++; $display("FAIL len0_done_latency: got cycle %0d want %0d", a_done_q[d0], a_start_q[s0] + 1);
        end
        checks++;
        if (a_rd_q.size() != r0 || a_wa_q.size() != w0) begin
            errors++; $display("FAIL len0_activity: got rd %0d we %0d want 0 and 0", a_rd_q.size() - r0, a_wa_q.size() - w0);
        end
        r0 = a_rd_q.size(); w0 = a_wa_q.size(); d0 = a_done_q.size(); s0 = a_start_q.size();
        pulse_a(27'd64);
        repeat (3) @(negedge clk);
        pulse_a(27'd8);
        wait_a_done(d0 + 1);
        checks++;
        if (a_start_q.size() - s0 != 1 || a_rd_q.size() - r0 != 1) begin
            errors++; $display("FAIL busy_start_ignored: got starts %0d rds %0d want 1 and 1", a_start_q.size() - s0, a_rd_q.size() - r0);
        end
        checks++;
        if (a_wa_q.size() - w0 != 64 || a_done_q.size() - d0 != 1) begin
            errors++; $display("FAIL busy_start_result: got we %0d done %0d want 64 and 1", a_wa_q.size() - w0, a_done_q.size() - d0);
        end
    endtask

    task automatic test_reset_mid();
        int r0 = a_rd_q.size(); int d0 = a_done_q.size(); int n = 0; int w1;
        pulse_a(27'd200);
        while (a_rd_q.size() < r0 + 2 && n < 2000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({a_busy, a_done, a_rd, a_we, a_addr, a_paddr, a_pdata} !== 67'd0) begin
            errors++; $display("FAIL midreset_outputs: got busy %b we %b addr %h paddr %0d want all 0", a_busy, a_we, a_addr, a_paddr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        r0 = a_rd_q.size(); w1 = a_wa_q.size();
        pulse_a(27'd64);
        wait_a_done(d0 + 1);
        checks++;
        if (a_done_q.size() - d0 != 1) begin errors++; $display("FAIL midreset_done: got %0d want 1", a_done_q.size() - d0); end
        checks++;
        if (a_rd_q.size() <= r0 || a_rd_q[r0] !== 29'h600_0000) begin
            errors++; $display("FAIL midreset_restart_addr: got %h want 6000000", (a_rd_q.size() > r0) ? a_rd_q[r0] : 29'h0);
        end
        checks++;
        if (a_wa_q.size() - w1 != 64) begin errors++; $display("FAIL midreset_we_count: got %0d want 64", a_wa_q.size() - w1); end
        for (int i = 0; i < 64 && w1 + i < a_wa_q.size(); i++) begin
            checks++;
            if (a_wa_q[w1+i] !== 27'(i) || a_wd_q[w1+i] !== pat(i)) begin
                errors++; $display("FAIL midreset_unit%0d: got addr %0d data %h want data %h", i, a_wa_q[w1+i], a_wd_q[w1+i], pat(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_len64();
        test_len200();
        test_random();
        test_dw16();
        test_len0_and_busy_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
